// File: rtl/student_tlul_arbiter.sv
// N-host to 1-device TL-UL arbiter: round-robin grant, one outstanding transaction,
// grant held from A request until the D response completes.
package student_tlul_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module student_tlul_arbiter
  import student_tlul_pkg::*;
#(
  parameter int unsigned NUM  = 2,
  parameter int unsigned IdxW = $clog2(NUM)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  tl_h2d_t [NUM-1:0]    tl_host_i,
  output tl_d2h_t [NUM-1:0]    tl_host_o,
  output tl_h2d_t              tl_device_o,
  input  tl_d2h_t              tl_device_i,
  output logic                 busy_o,
  output logic [IdxW-1:0]      grant_o
);

  typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [IdxW-1:0] prio_q, prio_d;
  logic [IdxW-1:0] winner;
  logic            any_req;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      prio_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
    end
  end

  // Round-robin search starting at prio_q.
  always_comb begin
    int unsigned idx;
    any_req = 1'b0;
    winner  = '0;
    for (int unsigned k = 0; k < NUM; k++) begin
      idx = (32'(prio_q) + k) % NUM;
      if (!any_req && tl_host_i[idx].a_valid) begin
        any_req = 1'b1;
        winner  = IdxW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          grant_d = winner;
          state_d = StReq;
        end
      end
      StReq: begin
        if (tl_host_i[grant_q].a_valid && tl_device_i.a_ready) begin
          state_d = StRsp;
        end else if (!tl_host_i[grant_q].a_valid) begin
          // Host withdrew its request without a handshake; give up the grant.
          state_d = StIdle;
        end
      end
      StRsp: begin
        if (tl_device_i.d_valid && tl_host_i[grant_q].d_ready) begin
          state_d = StIdle;
          prio_d  = (grant_q == IdxW'(NUM - 1)) ? '0 : grant_q + IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are forced idle while reset is asserted so an abandoned transaction leaks nothing.
  always_comb begin
    tl_device_o = '0;
    tl_host_o   = '0;
    busy_o      = (state_q != StIdle);
    grant_o     = grant_q;
    if (!rst_i) begin
      case (state_q)
        StReq: begin
          tl_device_o                = tl_host_i[grant_q];
          tl_device_o.d_ready        = 1'b0;
          tl_host_o[grant_q].a_ready = tl_device_i.a_ready;
        end
        StRsp: begin
          tl_device_o.d_ready        = tl_host_i[grant_q].d_ready;
          tl_host_o[grant_q]         = tl_device_i;
          tl_host_o[grant_q].a_ready = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
